video_decimate_buf: RTL and testbench

- Parametrised successor to video_sampling: takes one camera/HDMI pixel stream (de/vs/RGB565), decimates it by integer horizontal and vertical factors, and buffers the kept pixels in a show-ahead FIFO.
- Drained through a valid/ready handshake into the splicing/DDR write path.
- One block per input channel in the multi-channel splicer.
- Adds over the previous generation: configurable width, resolution, decimation and depth; frame flush on vsync; start-of-frame/end-of-line sidebands; overflow reporting.

---
 rtl/video_decimate_buf.sv | 174 +++++++++++++++++
 tb/tb_video_decimate_buf.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_decimate_buf.sv
// Pixel-stream decimator: keeps 1-of-H_DIV pixels on 1-of-V_DIV lines and queues them,
// tagged with start-of-frame/end-of-line, in a show-ahead FIFO that is flushed on every vsync.
module video_decimate_buf #(
    parameter int DATA_W     = 16,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int H_DIV      = 2,
    parameter int V_DIV      = 2,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vs_in,
    input  logic                            de_in,
    input  logic [DATA_W-1:0]               pix_in,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_sof,
    output logic                            out_eol,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_count,
    output logic                            overflow,
    output logic                            frame_start
);
    localparam int OUT_W = (H_ACTIVE + H_DIV - 1) / H_DIV;
    localparam int XW    = $clog2(H_ACTIVE + 1);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    localparam int HPW   = (H_DIV > 1) ? $clog2(H_DIV) : 1;
    localparam int VPW   = (V_DIV > 1) ? $clog2(V_DIV) : 1;
    localparam int OXW   = $clog2(OUT_W + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int EW    = DATA_W + 2;

    localparam logic [XW-1:0]  X_LIMIT  = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  Y_LIMIT  = YW'(V_ACTIVE);
    localparam logic [HPW-1:0] H_PH_MAX = HPW'(H_DIV - 1);
    localparam logic [VPW-1:0] V_PH_MAX = VPW'(V_DIV - 1);
    localparam logic [OXW-1:0] OUT_LAST = OXW'(OUT_W - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

    logic           vs_d;
    logic           de_d;
    logic [XW-1:0]  x_cnt;
    logic [YW-1:0]  y_cnt;
    logic [HPW-1:0] x_ph;
    logic [VPW-1:0] y_ph;
    logic [OXW-1:0] out_x;
    logic           sof_pend;

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [EW-1:0]  mem [FIFO_DEPTH];

    logic           vs_edge;
    logic           line_end;
    logic [XW-1:0]  x_cur;
    logic [YW-1:0]  y_cur;
    logic [HPW-1:0] x_ph_cur;
    logic [VPW-1:0] y_ph_cur;
    logic [OXW-1:0] out_x_cur;
    logic           sof_cur;
    logic           eol_cur;
    logic           x_active;
    logic           keep;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic [AW-1:0]  wr_addr;
    logic [EW-1:0]  head;

    assign vs_edge  = vs_in & ~vs_d;
    assign line_end = de_d & ~de_in;

    // On the vsync cycle every position counter reads as already cleared, so a pixel
    // arriving together with the edge is evaluated as the first pixel of the new frame.
    assign x_cur     = vs_edge ? '0 : x_cnt;
    assign y_cur     = vs_edge ? '0 : y_cnt;
    assign x_ph_cur  = vs_edge ? '0 : x_ph;
    assign y_ph_cur  = vs_edge ? '0 : y_ph;
    assign out_x_cur = vs_edge ? '0 : out_x;
    assign sof_cur   = vs_edge | sof_pend;
    assign eol_cur   = (out_x_cur == OUT_LAST);

    assign x_active = de_in & (x_cur < X_LIMIT);
    assign keep     = x_active & (y_cur < Y_LIMIT) & (x_ph_cur == '0) & (y_ph_cur == '0);

    assign full    = (count == FULL_CNT);
    assign pop     = out_valid & out_ready & ~vs_edge;
    assign push    = keep & (vs_edge | ~full | pop);
    assign drop    = keep & ~push;
    assign wr_addr = vs_edge ? '0 : wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d        <= 1'b0;
            de_d        <= 1'b0;
            frame_start <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            x_ph        <= '0;
            y_ph        <= '0;
            out_x       <= '0;
            sof_pend    <= 1'b1;
        end else begin
            vs_d        <= vs_in;
            de_d        <= de_in;
            frame_start <= vs_edge;
            sof_pend    <= push ? 1'b0 : sof_cur;
            if (line_end && !vs_edge) begin
                x_cnt <= '0;
                x_ph  <= '0;
                out_x <= '0;
                if (y_cnt != Y_LIMIT) begin
                    y_cnt <= y_cnt + 1'b1;
                end
                y_ph <= (y_ph == V_PH_MAX) ? '0 : y_ph + 1'b1;
            end else begin
                y_cnt <= y_cur;
                y_ph  <= y_ph_cur;
                x_cnt <= x_active ? x_cur + 1'b1 : x_cur;
                x_ph  <= x_active ? ((x_ph_cur == H_PH_MAX) ? '0 : x_ph_cur + 1'b1) : x_ph_cur;
                // Output column advances even for dropped pixels so eol stays positional.
                out_x <= keep ? out_x_cur + 1'b1 : out_x_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (vs_edge) begin
            rd_ptr   <= '0;
            wr_ptr   <= push ? AW'(1) : '0;
            count    <= push ? CW'(1) : '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_addr] <= {sof_cur, eol_cur, pix_in};
        end
    end

    // Storage is not reset, so the head is masked to keep outputs at zero while empty.
    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_sof    = out_valid & head[EW-1];
    assign out_eol    = out_valid & head[EW-2];
    assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
    assign fill_count = count;

endmodule

// File: tb/tb_video_decimate_buf.sv
// Self-checking bench for video_decimate_buf: a scoreboard of kept pixels checked on every
// pop, plus one task per scenario with its own direct checks.
module tb_video_decimate_buf;
    localparam int DATA_W     = 16;
    localparam int H_ACTIVE   = 8;
    localparam int V_ACTIVE   = 4;
    localparam int H_DIV      = 2;
    localparam int V_DIV      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_W      = 4;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    // {sof, eol, data} of one decimated frame of pix = x + 16*y
    localparam logic [DATA_W+1:0] EXP_FRAME [8] = '{
        18'h20000, 18'h00002, 18'h00004, 18'h10006,
        18'h00020, 18'h00022, 18'h00024, 18'h10026
    };

    logic              clk = 1'b0;
    logic              rst;
    logic              vs_in;
    logic              de_in;
    logic [DATA_W-1:0] pix_in;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     fill_count;
    logic              overflow;
    logic              frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W+1:0] sb [$];
    logic [DATA_W+1:0] popped [$];
    logic              model_sof_pend = 1'b1;
    logic              model_ovf      = 1'b0;
    logic              prev_flush     = 1'b0;
    logic              drv_keep       = 1'b0;
    logic              drv_eol        = 1'b0;
    logic              drv_flush      = 1'b0;
    logic [DATA_W-1:0] drv_data       = '0;

    video_decimate_buf #(
        .DATA_W    (DATA_W),
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .H_DIV     (H_DIV),
        .V_DIV     (V_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .pix_in     (pix_in),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count),
        .overflow   (overflow),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Scoreboard: the queue size is the expected occupancy; the front is the expected head.
    always @(negedge clk) begin : monitor
        logic exp_valid;
        logic do_pop;
        if (rst) begin
            sb.delete();
            model_sof_pend = 1'b1;
            model_ovf      = 1'b0;
            prev_flush     = 1'b0;
        end else begin
            exp_valid = (sb.size() != 0);
            n_checks++;
            if (fill_count !== CW'(sb.size())) begin
                n_fail++;
                $display("[TB] FAIL sb_fill_count: got %0d expected %0d at %0t", fill_count, sb.size(), $time);
            end
            n_checks++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("[TB] FAIL sb_out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
            end
            n_checks++;
            if (overflow !== model_ovf) begin
                n_fail++;
                $display("[TB] FAIL sb_overflow: got %b expected %b at %0t", overflow, model_ovf, $time);
            end
            n_checks++;
            if (frame_start !== prev_flush) begin
                n_fail++;
                $display("[TB] FAIL sb_frame_start: got %b expected %b at %0t", frame_start, prev_flush, $time);
            end
            do_pop = exp_valid && out_ready && !drv_flush;
            if (do_pop) begin
                n_checks++;
                if ({out_sof, out_eol, out_data} !== sb[0]) begin
                    n_fail++;
                    $display("[TB] FAIL sb_head: got %h expected %h at %0t", {out_sof, out_eol, out_data}, sb[0], $time);
                end
                popped.push_back({out_sof, out_eol, out_data});
            end
            if (drv_flush) begin
                sb.delete();
                model_ovf      = 1'b0;
                model_sof_pend = 1'b1;
            end else if (do_pop) begin
                void'(sb.pop_front());
            end
            if (drv_keep) begin
                if (sb.size() < FIFO_DEPTH) begin
                    sb.push_back({model_sof_pend, drv_eol, drv_data});
                    model_sof_pend = 1'b0;
                end else begin
                    model_ovf = 1'b1;
                end
            end
            prev_flush = drv_flush;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vs();
        vs_in     = 1'b1;
        drv_flush = 1'b1;
        step();
        vs_in     = 1'b0;
        drv_flush = 1'b0;
        step();
    endtask

    // Drives n pixels of line y; gap=0 leaves de_in high so a line can be cut short.
    task automatic send_line(input int y, input int n, input bit ready_on_keep, input int gap);
        for (int x = 0; x < n; x++) begin
            de_in    = 1'b1;
            pix_in   = DATA_W'(x + 16 * y);
            drv_data = pix_in;
            drv_keep = (x < H_ACTIVE) && (y < V_ACTIVE) && (x % H_DIV == 0) && (y % V_DIV == 0);
            drv_eol  = ((x / H_DIV) == OUT_W - 1);
            if (ready_on_keep) out_ready = drv_keep;
            step();
        end
        drv_keep = 1'b0;
        drv_eol  = 1'b0;
        if (ready_on_keep) out_ready = 1'b0;
        if (gap > 0) de_in = 1'b0;
        repeat (gap) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; pix_in = '0; out_ready = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({out_valid, out_sof, out_eol, overflow, frame_start} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {out_valid, out_sof, out_eol, overflow, frame_start});
        end
        n_checks++;
        if (fill_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_fill_count: got %0d expected 0", fill_count);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_frame();
        popped.delete();
        out_ready = 1'b1;
        pulse_vs();
        for (int y = 0; y < V_ACTIVE; y++) send_line(y, H_ACTIVE, 1'b0, 2);
        repeat (3) step();
        n_checks++;
        if (popped.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL basic_count: got %0d expected 8", popped.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= popped.size()) begin
                n_fail++;
                $display("[TB] FAIL basic_seq[%0d]: got none expected %h", i, EXP_FRAME[i]);
            end else if (popped[i] !== EXP_FRAME[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_seq[%0d]: got %h expected %h", i, popped[i], EXP_FRAME[i]);
            end
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        pulse_vs();
        send_line(0, H_ACTIVE, 1'b0, 2);
        n_checks++;
        if (fill_count !== CW'(4)) begin
            n_fail++;
            $display("[TB] FAIL ovf_fill_after_line0: got %0d expected 4", fill_count);
        end
        for (int y = 1; y < V_ACTIVE; y++) send_line(y, H_ACTIVE, 1'b0, 2);
        n_checks++;
        if (overflow !== 1'b1 || fill_count !== CW'(4)) begin
            n_fail++;
            $display("[TB] FAIL ovf_state: got overflow=%b fill=%0d expected overflow=1 fill=4", overflow, fill_count);
        end
        n_checks++;
        if ({out_valid, out_sof, out_data} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL ovf_head: got valid=%b sof=%b data=%h expected 1 1 0000", out_valid, out_sof, out_data);
        end
    endtask

    task automatic test_flush();
        vs_in     = 1'b1;
        drv_flush = 1'b1;
        step();
        vs_in     = 1'b0;
        drv_flush = 1'b0;
        n_checks++;
        if ({frame_start, out_valid, overflow} !== 3'b100 || fill_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL flush_state: got fs=%b valid=%b ovf=%b fill=%0d expected 1 0 0 0",
                     frame_start, out_valid, overflow, fill_count);
        end
        step();
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_pulse_width: got %b expected 0", frame_start);
        end
    endtask

    task automatic test_full_push_pop();
        popped.delete();
        out_ready = 1'b0;
        send_line(0, H_ACTIVE, 1'b0, 2);
        send_line(1, H_ACTIVE, 1'b0, 2);
        send_line(2, H_ACTIVE, 1'b1, 2);
        n_checks++;
        if (fill_count !== CW'(4) || overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fullpp_state: got fill=%0d ovf=%b expected fill=4 ovf=0", fill_count, overflow);
        end
        n_checks++;
        if (out_data !== 16'h0020) begin
            n_fail++;
            $display("[TB] FAIL fullpp_head: got %h expected 0020", out_data);
        end
        out_ready = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= popped.size()) begin
                n_fail++;
                $display("[TB] FAIL fullpp_seq[%0d]: got none expected %h", i, EXP_FRAME[i]);
            end else if (popped[i] !== EXP_FRAME[i]) begin
                n_fail++;
                $display("[TB] FAIL fullpp_seq[%0d]: got %h expected %h", i, popped[i], EXP_FRAME[i]);
            end
        end
    endtask

    task automatic test_long_line();
        popped.delete();
        out_ready = 1'b1;
        pulse_vs();
        send_line(0, H_ACTIVE + 2, 1'b0, 3);
        n_checks++;
        if (popped.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL long_count: got %0d expected 4", popped.size());
        end else begin
            n_checks++;
            if (popped[3] !== 18'h10006) begin
                n_fail++;
                $display("[TB] FAIL long_last: got %h expected 10006", popped[3]);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        out_ready = 1'b0;
        pulse_vs();
        send_line(0, 5, 1'b0, 0);
        n_checks++;
        if (fill_count !== CW'(3)) begin
            n_fail++;
            $display("[TB] FAIL rstmid_pre_fill: got %0d expected 3", fill_count);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, frame_start} !== 2'b00 || fill_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_async: got valid=%b fs=%b fill=%0d expected 0 0 0", out_valid, frame_start, fill_count);
        end
        de_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        popped.delete();
        out_ready = 1'b1;
        send_line(0, H_ACTIVE, 1'b0, 3);
        n_checks++;
        if (popped.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL rstmid_count: got %0d expected 4", popped.size());
        end else begin
            n_checks++;
            if (popped[0] !== 18'h20000) begin
                n_fail++;
                $display("[TB] FAIL rstmid_first_sof: got %h expected 20000", popped[0]);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic_frame();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_long_line();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
